// File: rtl/spi_pkg.sv
// Shared SPI master definitions: FSM encoding, frame geometry and sclk polarity.
// SPI_IDLE_HIGH_SCLK_EN selects sclk idle level 1 (CPOL=1, CPHA=1); default is mode 0.
package spi_pkg;

    typedef enum logic [2:0] {
        StIdle,
        StSetup,
        StAddr,
        StData,
        StHold,
        StDone
    } spi_state_e;

    localparam int unsigned SPI_FRAME_BITS = 16;
    localparam int unsigned SPI_BYTE_BITS  = 8;
    localparam int unsigned RW_BIT         = 7;

`ifdef SPI_IDLE_HIGH_SCLK_EN
    localparam logic SCLK_IDLE = 1'b1;
`else
    localparam logic SCLK_IDLE = 1'b0;
`endif

    // Idle-high build is CPHA=1: mosi launches on the idle->active edge, miso samples on return.
    localparam logic LAUNCH_ON_ACTIVE = SCLK_IDLE;

endpackage

// File: rtl/spi_clkdiv.sv
// Half-period tick generator: one-cycle tick every CLKDIV enabled cycles, held at 0 when disabled.
module spi_clkdiv #(
    parameter int unsigned CLKDIV = 4
) (
    input  logic clk,
    input  logic reset,
    input  logic en,
    output logic tick
);

    localparam int unsigned CW = $clog2(CLKDIV);

    logic [CW-1:0] cnt_q, cnt_d;

    assign tick = en && (cnt_q == CW'(CLKDIV - 1));

    always_comb begin
        cnt_d = cnt_q;
        if (!en) begin
            cnt_d = '0;
        end else if (tick) begin
            cnt_d = '0;
        end else begin
            cnt_d = cnt_q + 1'b1;
        end
    end

    always_ff @(posedge clk) begin
        if (reset) begin
            cnt_q <= '0;
        end else begin
            cnt_q <= cnt_d;
        end
    end

endmodule

// File: rtl/spi_master_ctrl.sv
// SPI master for one address byte plus one data byte per frame, with read capture into rdata.
// Define SPI_IDLE_HIGH_SCLK_EN for sclk idle-high (CPOL=1, CPHA=1); timing is identical.
module spi_master_ctrl
    import spi_pkg::*;
#(
    parameter int unsigned CLKDIV = 4
) (
    input  logic       clk,
    input  logic       reset,
    input  logic       start,
    input  logic [7:0] addr_in,
    input  logic [7:0] data_in,
    input  logic       miso,
    output logic       mosi,
    output logic       sclk,
    output logic       cs_n,
    output logic       busy,
    output logic       done,
    output logic [7:0] rdata
);

    localparam logic [3:0] ADDR_LAST  = 4'(SPI_BYTE_BITS - 1);
    localparam logic [3:0] FRAME_LAST = 4'(SPI_FRAME_BITS - 1);

    spi_state_e                  state_q, state_d;
    logic                        phase_q, phase_d;
    logic [3:0]                  bit_q, bit_d, bit_nxt;
    logic [SPI_FRAME_BITS-1:0]   frame_q, frame_d;
    logic                        mosi_q, mosi_d;
    logic [SPI_BYTE_BITS-1:0]    rx_q, rx_d;
    logic [SPI_BYTE_BITS-1:0]    rdata_q, rdata_d;
    logic                        tick;
    logic                        shifting;

    assign busy     = (state_q == StSetup) || (state_q == StAddr) ||
                      (state_q == StData)  || (state_q == StHold);
    assign cs_n     = ~busy;
    assign done     = (state_q == StDone);
    assign shifting = (state_q == StAddr) || (state_q == StData);
    assign sclk     = SCLK_IDLE ^ (shifting && phase_q);
    assign mosi     = mosi_q;
    assign rdata    = rdata_q;

    spi_clkdiv #(
        .CLKDIV(CLKDIV)
    ) u_clkdiv (
        .clk  (clk),
        .reset(reset),
        .en   (busy),
        .tick (tick)
    );

    always_comb begin
        state_d = state_q;
        phase_d = phase_q;
        bit_d   = bit_q;
        frame_d = frame_q;
        mosi_d  = mosi_q;
        rx_d    = rx_q;
        rdata_d = rdata_q;
        bit_nxt = bit_q + 4'd1;
        unique case (state_q)
            StIdle: begin
                if (start) begin
                    // Read frames transmit zeros in the data byte.
                    frame_d = {addr_in, addr_in[RW_BIT] ? 8'h00 : data_in};
                    rx_d    = '0;
                    state_d = StSetup;
                end
            end
            StSetup: begin
                if (tick) begin
                    state_d = StAddr;
                    phase_d = 1'b0;
                    bit_d   = '0;
                    if (!LAUNCH_ON_ACTIVE) mosi_d = frame_q[FRAME_LAST];
                end
            end
            StAddr, StData: begin
                if (tick) begin
                    phase_d = ~phase_q;
                    if (!phase_q) begin
                        if (LAUNCH_ON_ACTIVE) begin
                            mosi_d = frame_q[~bit_q];
                        end else if (state_q == StData) begin
                            rx_d = {rx_q[SPI_BYTE_BITS-2:0], miso};
                        end
                    end else begin
                        if (LAUNCH_ON_ACTIVE) begin
                            if (state_q == StData) rx_d = {rx_q[SPI_BYTE_BITS-2:0], miso};
                        end else if (bit_q != FRAME_LAST) begin
                            mosi_d = frame_q[~bit_nxt];
                        end
                        bit_d = bit_nxt;
                        if (bit_q == ADDR_LAST)  state_d = StData;
                        if (bit_q == FRAME_LAST) state_d = StHold;
                    end
                end
            end
            StHold: begin
                if (tick) begin
                    state_d = StDone;
                    mosi_d  = 1'b0;
                    if (frame_q[SPI_BYTE_BITS + RW_BIT]) rdata_d = rx_q;
                end
            end
            StDone: begin
                state_d = StIdle;
            end
            default: begin
                state_d = StIdle;
            end
        endcase
    end

    always_ff @(posedge clk) begin
        if (reset) begin
            state_q <= StIdle;
            phase_q <= 1'b0;
            bit_q   <= '0;
            frame_q <= '0;
            mosi_q  <= 1'b0;
            rx_q    <= '0;
            rdata_q <= '0;
        end else begin
            state_q <= state_d;
            phase_q <= phase_d;
            bit_q   <= bit_d;
            frame_q <= frame_d;
            mosi_q  <= mosi_d;
            rx_q    <= rx_d;
            rdata_q <= rdata_d;
        end
    end

endmodule

// File: tb/tb_spi_master_ctrl.sv
// Directed self-checking bench for spi_master_ctrl; honours SPI_IDLE_HIGH_SCLK_EN for the sclk level.
module tb_spi_master_ctrl;

    localparam int unsigned CLKDIV   = 4;
    localparam int          DONE_CYC = 34 * CLKDIV + 1;
`ifdef SPI_IDLE_HIGH_SCLK_EN
    localparam logic IDLE_LVL = 1'b1;
`else
    localparam logic IDLE_LVL = 1'b0;
`endif

    logic       clk, reset, start, miso;
    logic [7:0] addr_in, data_in;
    logic       mosi, sclk, cs_n, busy, done;
    logic [7:0] rdata;

    int n_cmp = 0;
    int n_err = 0;

    logic [15:0] cap_bits;
    int          cap_rises, cap_done_cyc, cap_done_cnt, cap_setup_bad;
    logic [7:0]  cap_rdata;
    logic        cap_busy1, cap_csn1;

    spi_master_ctrl #(
        .CLKDIV(CLKDIV)
    ) dut (
        .clk    (clk),
        .reset  (reset),
        .start  (start),
        .addr_in(addr_in),
        .data_in(data_in),
        .miso   (miso),
        .mosi   (mosi),
        .sclk   (sclk),
        .cs_n   (cs_n),
        .busy   (busy),
        .done   (done),
        .rdata  (rdata)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    // One start pulse, then watch the frame: capture mosi on every sclk rise (the slave
    // sampling edge in both modes) and play the slave byte on miso during the data byte.
    task automatic run_frame(input logic [7:0] a, input logic [7:0] d,
                             input logic [7:0] slave, input bit pulse);
        logic prev;
        @(posedge clk); #1;
        addr_in = a; data_in = d; start = 1'b1; miso = 1'b0;
        cap_bits = '0; cap_rises = 0; cap_done_cyc = -1; cap_done_cnt = 0;
        cap_setup_bad = 0; cap_rdata = 8'hxx;
        prev = sclk;
        for (int cyc = 1; cyc <= DONE_CYC + 60; cyc++) begin
            @(posedge clk); #1;
            if (cyc == 1) begin
                start = 1'b0; cap_busy1 = busy; cap_csn1 = cs_n;
                addr_in = ~a; data_in = ~d;
            end
            if (cyc <= CLKDIV && sclk !== IDLE_LVL) cap_setup_bad++;
            if (pulse && cyc == 40) start = 1'b1;
            if (pulse && cyc == 41) start = 1'b0;
            if (pulse && cap_done_cyc > 0 && cyc == cap_done_cyc + 1) start = 1'b0;
            if (done === 1'b1) begin
                cap_done_cnt++;
                if (cap_done_cyc < 0) begin
                    cap_done_cyc = cyc; cap_rdata = rdata;
                    if (pulse) start = 1'b1;
                end
            end
            if (sclk === 1'b1 && prev === 1'b0) begin
                cap_bits = {cap_bits[14:0], mosi};
                cap_rises++;
                if (cap_rises >= 8 && cap_rises < 16) miso = slave[15 - cap_rises];
            end
            prev = sclk;
        end
        start = 1'b0;
    endtask

    task automatic test_reset();
        reset = 1'b1; start = 1'b1; addr_in = 8'h05; data_in = 8'hA5; miso = 1'b0;
        repeat (3) @(posedge clk);
        #1;
        n_cmp++; if (cs_n !== 1'b1) begin n_err++; $display("FAIL reset_cs_n: got %b want 1", cs_n); end
        n_cmp++; if (busy !== 1'b0) begin n_err++; $display("FAIL reset_busy: got %b want 0", busy); end
        n_cmp++; if (done !== 1'b0) begin n_err++; $display("FAIL reset_done: got %b want 0", done); end
        n_cmp++; if (sclk !== IDLE_LVL) begin n_err++; $display("FAIL reset_sclk: got %b want %b", sclk, IDLE_LVL); end
        n_cmp++; if (mosi !== 1'b0) begin n_err++; $display("FAIL reset_mosi: got %b want 0", mosi); end
        n_cmp++; if (rdata !== 8'h00) begin n_err++; $display("FAIL reset_rdata: got %h want 00", rdata); end
        start = 1'b0; reset = 1'b0;
        @(posedge clk); #1;
        n_cmp++; if (cs_n !== 1'b1) begin n_err++; $display("FAIL reset_prio_cs_n: got %b want 1", cs_n); end
    endtask

    task automatic test_write();
        run_frame(8'h05, 8'hA5, 8'h00, 1'b0);
        n_cmp++; if (cap_bits !== 16'h05A5) begin n_err++; $display("FAIL write_mosi: got %h want 05a5", cap_bits); end
        n_cmp++; if (cap_rises !== 16) begin n_err++; $display("FAIL write_edges: got %0d want 16", cap_rises); end
        n_cmp++; if (cap_done_cyc !== DONE_CYC) begin n_err++; $display("FAIL write_done_cycle: got %0d want %0d", cap_done_cyc, DONE_CYC); end
        n_cmp++; if (cap_done_cnt !== 1) begin n_err++; $display("FAIL write_done_count: got %0d want 1", cap_done_cnt); end
        n_cmp++; if (cap_rdata !== 8'h00) begin n_err++; $display("FAIL write_rdata: got %h want 00", cap_rdata); end
        n_cmp++; if (cap_busy1 !== 1'b1) begin n_err++; $display("FAIL write_busy_c1: got %b want 1", cap_busy1); end
        n_cmp++; if (cap_csn1 !== 1'b0) begin n_err++; $display("FAIL write_csn_c1: got %b want 0", cap_csn1); end
        n_cmp++; if (cap_setup_bad !== 0) begin n_err++; $display("FAIL write_setup_sclk: got %0d bad cycles want 0", cap_setup_bad); end
    endtask

    task automatic test_read();
        run_frame(8'h85, 8'h5A, 8'h3C, 1'b0);
        n_cmp++; if (cap_bits !== 16'h8500) begin n_err++; $display("FAIL read_mosi: got %h want 8500", cap_bits); end
        n_cmp++; if (cap_rdata !== 8'h3C) begin n_err++; $display("FAIL read_rdata_at_done: got %h want 3c", cap_rdata); end
        n_cmp++; if (cap_done_cyc !== DONE_CYC) begin n_err++; $display("FAIL read_done_cycle: got %0d want %0d", cap_done_cyc, DONE_CYC); end
        n_cmp++; if (rdata !== 8'h3C) begin n_err++; $display("FAIL read_rdata_hold: got %h want 3c", rdata); end
        // A write frame must leave the captured read byte alone.
        run_frame(8'h12, 8'h34, 8'hFF, 1'b0);
        n_cmp++; if (cap_bits !== 16'h1234) begin n_err++; $display("FAIL write2_mosi: got %h want 1234", cap_bits); end
        n_cmp++; if (rdata !== 8'h3C) begin n_err++; $display("FAIL write2_rdata: got %h want 3c", rdata); end
    endtask

    task automatic test_start_while_busy();
        run_frame(8'h05, 8'hA5, 8'h00, 1'b1);
        n_cmp++; if (cap_done_cnt !== 1) begin n_err++; $display("FAIL busy_start_done_count: got %0d want 1", cap_done_cnt); end
        n_cmp++; if (cap_done_cyc !== DONE_CYC) begin n_err++; $display("FAIL busy_start_done_cycle: got %0d want %0d", cap_done_cyc, DONE_CYC); end
        n_cmp++; if (cap_bits !== 16'h05A5) begin n_err++; $display("FAIL busy_start_mosi: got %h want 05a5", cap_bits); end
        n_cmp++; if (cs_n !== 1'b1) begin n_err++; $display("FAIL busy_start_idle_cs_n: got %b want 1", cs_n); end
    endtask

    task automatic test_mid_reset();
        logic prev;
        int   act, dcnt;
        bit   fired;
        @(posedge clk); #1;
        addr_in = 8'h85; data_in = 8'h00; start = 1'b1; miso = 1'b1;
        act = 0; dcnt = 0; fired = 1'b0; prev = sclk;
        for (int cyc = 1; cyc <= DONE_CYC + 20 && !fired; cyc++) begin
            @(posedge clk); #1;
            if (cyc == 1) start = 1'b0;
            if (done === 1'b1) dcnt++;
            if (sclk === ~IDLE_LVL && prev === IDLE_LVL) act++;
            prev = sclk;
            // 8 address edges, then the 5th data edge.
            if (act == 13) begin
                reset = 1'b1; fired = 1'b1;
            end
        end
        n_cmp++; if (!fired) begin n_err++; $display("FAIL midreset_edge_timeout: got %0d active edges want 13", act); end
        @(posedge clk); #1;
        reset = 1'b0;
        n_cmp++; if (cs_n !== 1'b1) begin n_err++; $display("FAIL midreset_cs_n: got %b want 1", cs_n); end
        n_cmp++; if (busy !== 1'b0) begin n_err++; $display("FAIL midreset_busy: got %b want 0", busy); end
        n_cmp++; if (rdata !== 8'h00) begin n_err++; $display("FAIL midreset_rdata: got %h want 00", rdata); end
        n_cmp++; if (sclk !== IDLE_LVL) begin n_err++; $display("FAIL midreset_sclk: got %b want %b", sclk, IDLE_LVL); end
        for (int cyc = 0; cyc < DONE_CYC; cyc++) begin
            if (done === 1'b1) dcnt++;
            @(posedge clk); #1;
        end
        n_cmp++; if (dcnt !== 0) begin n_err++; $display("FAIL midreset_no_done: got %0d pulses want 0", dcnt); end
    endtask

    task automatic test_back_to_back();
        int  d1, d2, dcnt, high_run;
        bit  counting;
        @(posedge clk); #1;
        addr_in = 8'h05; data_in = 8'hA5; start = 1'b1;
        d1 = -1; d2 = -1; dcnt = 0; high_run = 0; counting = 1'b0;
        for (int cyc = 1; cyc <= 2 * DONE_CYC + 60; cyc++) begin
            @(posedge clk); #1;
            if (counting) begin
                if (cs_n === 1'b1) high_run++;
                else counting = 1'b0;
            end
            if (done === 1'b1) begin
                dcnt++;
                if (d1 < 0) begin
                    d1 = cyc; counting = 1'b1;
                end else if (d2 < 0) begin
                    d2 = cyc;
                end
            end
            if (d1 > 0 && cyc == d1 + 8) start = 1'b0;
        end
        start = 1'b0;
        n_cmp++; if (dcnt !== 2) begin n_err++; $display("FAIL b2b_done_count: got %0d want 2", dcnt); end
        n_cmp++; if (d1 !== DONE_CYC) begin n_err++; $display("FAIL b2b_first_done: got %0d want %0d", d1, DONE_CYC); end
        n_cmp++; if (d2 - d1 !== 34 * CLKDIV + 2) begin n_err++; $display("FAIL b2b_spacing: got %0d want %0d", d2 - d1, 34 * CLKDIV + 2); end
        // After the done cycle cs_n stays high for the single IDLE cycle only.
        n_cmp++; if (high_run !== 1) begin n_err++; $display("FAIL b2b_cs_gap: got %0d want 1", high_run); end
        n_cmp++; if (cs_n !== 1'b1) begin n_err++; $display("FAIL b2b_end_idle: got %b want 1", cs_n); end
    endtask

    initial begin
        reset = 1'b1; start = 1'b0; addr_in = '0; data_in = '0; miso = 1'b0;
        test_reset();
        test_write();
        test_read();
        test_start_while_busy();
        test_mid_reset();
        test_back_to_back();
        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
        $finish;
    end

endmodule
